// File: rtl/reg_file.sv
// RV32I integer register file: 32 x 32-bit, one write port, two combinational read ports.
// x0 reads as zero and has no storage; a same-cycle write is forwarded to matching read ports.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic              wr_live;
  logic              byp1;
  logic              byp2;

  // WE is tested before RD so an unknown index with WE=0 cannot select a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (WE && (RD == ADDR_W'(i))) begin
          regs[i] <= WD;
        end
      end
    end
  end

  always_comb begin
    rd1_q = '0;
    rd2_q = '0;
    for (int i = 1; i < NREG; i++) begin
      if (RS1 == ADDR_W'(i)) rd1_q = regs[i];
      if (RS2 == ADDR_W'(i)) rd2_q = regs[i];
    end
  end

  // Forwarding of the write-back word; never applies to x0.
  assign wr_live = WE && (RD != '0);
  assign byp1    = wr_live && (RS1 == RD);
  assign byp2    = wr_live && (RS2 == RD);

  assign RD1 = byp1 ? WD : rd1_q;
  assign RD2 = byp2 ? WD : rd2_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, readback, x0, bypass, WE gating, full sweep.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        WE;
  logic [4:0]  RD;
  logic [31:0] WD;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int n_cmp = 0;
  int n_err = 0;

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .WE(WE), .RD(RD), .WD(WD),
    .RS1(RS1), .RS2(RS2), .RD1(RD1), .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic write(input logic [4:0] idx, input logic [31:0] val);
    WE = 1'b1; RD = idx; WD = val;
    tick();
    WE = 1'b0;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      RS1 = 5'(i); RS2 = 5'(31 - i);
      settle();
      check($sformatf("%s_rd1_x%0d", tag, i), RD1, 32'h0);
      check($sformatf("%s_rd2_x%0d", tag, 31 - i), RD2, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; WE = 1'b0; RD = '0; WD = '0; RS1 = '0; RS2 = '0;
    tick();
    tick();
    rst = 1'b0;
    sweep_zero("reset_state");

    // Reset clears a previously written register.
    write(5'd5, 32'hDEADBEEF);
    RS1 = 5'd5; settle();
    check("pre_reset_x5", RD1, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    RS1 = 5'd5; settle();
    check("post_reset_x5", RD1, 32'h0);
    sweep_zero("reset_clear");

    // Write and read back at both ends of the index range.
    write(5'd1, 32'h00000011);
    write(5'd31, 32'hFFFFFFFF);
    RS1 = 5'd1; RS2 = 5'd31; settle();
    check("readback_x1", RD1, 32'h00000011);
    check("readback_x31", RD2, 32'hFFFFFFFF);

    // Writes to x0 are discarded and never forwarded.
    WE = 1'b1; RD = 5'd0; WD = 32'h12345678; RS1 = 5'd0; RS2 = 5'd0;
    settle();
    check("x0_same_cycle_rd1", RD1, 32'h0);
    check("x0_same_cycle_rd2", RD2, 32'h0);
    tick();
    WE = 1'b0; settle();
    check("x0_next_rd1", RD1, 32'h0);
    check("x0_next_rd2", RD2, 32'h0);
    RS1 = 5'd1; RS2 = 5'd31; settle();
    check("x0_write_keeps_x1", RD1, 32'h00000011);
    check("x0_write_keeps_x31", RD2, 32'hFFFFFFFF);

    // Same-cycle bypass on both ports; a non-matching port is not bypassed.
    write(5'd7, 32'h00000001);
    WE = 1'b1; RD = 5'd7; WD = 32'h000000AA; RS1 = 5'd7; RS2 = 5'd7;
    settle();
    check("bypass_rd1", RD1, 32'h000000AA);
    check("bypass_rd2", RD2, 32'h000000AA);
    RS2 = 5'd1; settle();
    check("bypass_other_port", RD2, 32'h00000011);
    tick();
    WE = 1'b0; RS2 = 5'd7; settle();
    check("bypass_after_rd1", RD1, 32'h000000AA);
    check("bypass_after_rd2", RD2, 32'h000000AA);

    // WE=0 leaves registers alone, even with an unknown index.
    write(5'd3, 32'h00000033);
    WE = 1'b0; RD = 5'd3; WD = 32'h5555AAAA;
    tick();
    RD = 'x; WD = 32'h0BADF00D;
    tick();
    RD = 5'd0;
    RS1 = 5'd3; RS2 = 5'd1; settle();
    check("we0_keeps_x3", RD1, 32'h00000033);
    check("we0_keeps_x1", RD2, 32'h00000011);

    // Reset wins over a simultaneous write.
    rst = 1'b1; WE = 1'b1; RD = 5'd4; WD = 32'hCAFEF00D;
    tick();
    rst = 1'b0; WE = 1'b0; RD = 5'd0;
    RS1 = 5'd4; RS2 = 5'd3; settle();
    check("rst_prio_x4", RD1, 32'h0);
    check("rst_clears_x3", RD2, 32'h0);

    // Back-to-back writes to one index: the last one wins.
    WE = 1'b1; RD = 5'd9; WD = 32'h00000001;
    tick();
    WD = 32'h00000002;
    tick();
    WE = 1'b0;
    RS1 = 5'd9; settle();
    check("b2b_last_wins", RD1, 32'h00000002);

    // Full sweep in consecutive cycles, then read pairs (i, 32-i).
    WE = 1'b1;
    for (int i = 1; i < 32; i++) begin
      RD = 5'(i); WD = 32'(i) * 32'h01010101;
      tick();
    end
    WE = 1'b0; RD = 5'd0;
    for (int i = 1; i < 32; i++) begin
      RS1 = 5'(i); RS2 = 5'(32 - i); settle();
      check($sformatf("sweep_rd1_x%0d", i), RD1, 32'(i) * 32'h01010101);
      check($sformatf("sweep_rd2_x%0d", 32 - i), RD2, 32'(32 - i) * 32'h01010101);
    end
    RS1 = 5'd0; settle();
    check("sweep_x0", RD1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
